// File: rtl/debug_latch_dumper.sv
// debug_latch_dumper
// Debug sequencer behind the pipeline latch-select mux. On request it walks
// the mux selector through a fixed table of latch codes, captures each
// registered 32-bit word and streams it MSB byte first to a byte-wide UART
// transmitter. A dump is one header byte followed by every table word.
module debug_latch_dumper #(
    parameter int         DATA_W    = 32,
    parameter int         SEL_W     = 7,
    parameter int         N_ENTRIES = 20,
    parameter logic [7:0] HEADER    = 8'hA5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic [DATA_W-1:0] i_mux_data,
    input  logic              i_tx_ready,
    input  logic              i_tx_done,
    output logic [SEL_W-1:0]  o_mux_sel,
    output logic [7:0]        o_tx_data,
    output logic              o_tx_start,
    output logic              o_busy,
    output logic              o_done
);

    // Index widths for the entry counter and the byte-within-word counter.
    localparam int IDX_W     = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1;
    localparam int TBL_DEPTH = 1 << IDX_W;
    localparam int N_BYTES   = DATA_W / 8;
    localparam int BYTE_W    = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;

    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(N_ENTRIES - 1);
    localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(N_BYTES - 1);

    typedef enum logic [3:0] {
        IDLE,
        HDR,
        HWAIT,
        SEL,
        SETTLE,
        LOAD,
        SEND,
        BWAIT,
        FIN
    } state_t;

    // Fixed dump order of latch codes; unused slots of the power-of-two
    // table read as code 0 so the lookup never indexes outside the array.
    function automatic logic [SEL_W-1:0] tableCode(input int idx);
        logic [SEL_W-1:0] code;
        case (idx)
            0:       code = SEL_W'(7'h00);
            1:       code = SEL_W'(7'h01);
            2:       code = SEL_W'(7'h10);
            3:       code = SEL_W'(7'h11);
            4:       code = SEL_W'(7'h13);
            5:       code = SEL_W'(7'h14);
            6:       code = SEL_W'(7'h15);
            7:       code = SEL_W'(7'h16);
            8:       code = SEL_W'(7'h20);
            9:       code = SEL_W'(7'h21);
            10:      code = SEL_W'(7'h23);
            11:      code = SEL_W'(7'h24);
            12:      code = SEL_W'(7'h25);
            13:      code = SEL_W'(7'h30);
            14:      code = SEL_W'(7'h31);
            15:      code = SEL_W'(7'h32);
            16:      code = SEL_W'(7'h33);
            17:      code = SEL_W'(7'h34);
            18:      code = SEL_W'(7'h40);
            19:      code = SEL_W'(7'h41);
            default: code = '0;
        endcase
        return code;
    endfunction

    state_t              stateReg,  stateNext;
    logic [IDX_W-1:0]    idxReg,    idxNext;
    logic [BYTE_W-1:0]   byteReg,   byteNext;
    logic [DATA_W-1:0]   capReg,    capNext;
    logic [SEL_W-1:0]    muxSelReg, muxSelNext;

    logic [SEL_W-1:0]    selTable [TBL_DEPTH];
    logic [7:0]          capBytes [N_BYTES];

    // Selector lookup table, one constant entry per slot.
    generate
        for (genvar gi = 0; gi < TBL_DEPTH; gi++) begin : g_sel_table
            assign selTable[gi] = tableCode(gi);
        end
    endgenerate

    // Byte lanes of the captured word; lane 0 is the most significant byte
    // so the byte counter directly gives transmit order.
    generate
        for (genvar gi = 0; gi < N_BYTES; gi++) begin : g_cap_bytes
            assign capBytes[gi] = capReg[DATA_W-1-8*gi -: 8];
        end
    endgenerate

    // State and datapath registers; reset aborts any dump immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateReg  <= IDLE;
            idxReg    <= '0;
            byteReg   <= '0;
            capReg    <= '0;
            muxSelReg <= '0;
        end else begin
            stateReg  <= stateNext;
            idxReg    <= idxNext;
            byteReg   <= byteNext;
            capReg    <= capNext;
            muxSelReg <= muxSelNext;
        end
    end

    // Next-state logic. The selector is registered on leaving SEL so the mux
    // register updates one clock later and LOAD samples it exactly two clocks
    // after the selector changed.
    always_comb begin
        stateNext  = stateReg;
        idxNext    = idxReg;
        byteNext   = byteReg;
        capNext    = capReg;
        muxSelNext = muxSelReg;

        case (stateReg)
            IDLE: begin
                muxSelNext = '0;
                idxNext    = '0;
                byteNext   = '0;
                if (i_start) begin
                    stateNext = HDR;
                end
            end
            HDR: begin
                if (i_tx_ready) begin
                    stateNext = HWAIT;
                end
            end
            HWAIT: begin
                if (i_tx_done) begin
                    idxNext   = '0;
                    stateNext = SEL;
                end
            end
            SEL: begin
                muxSelNext = selTable[idxReg];
                stateNext  = SETTLE;
            end
            SETTLE: begin
                stateNext = LOAD;
            end
            LOAD: begin
                capNext   = i_mux_data;
                byteNext  = '0;
                stateNext = SEND;
            end
            SEND: begin
                if (i_tx_ready) begin
                    stateNext = BWAIT;
                end
            end
            BWAIT: begin
                if (i_tx_done) begin
                    if (byteReg != LAST_BYTE) begin
                        byteNext  = byteReg + BYTE_W'(1);
                        stateNext = SEND;
                    end else if (idxReg != LAST_IDX) begin
                        idxNext   = idxReg + IDX_W'(1);
                        stateNext = SEL;
                    end else begin
                        muxSelNext = '0;
                        stateNext  = FIN;
                    end
                end
            end
            FIN: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // Output decode. Transmit data is held from launch through the wait
    // state so it stays stable until the byte has been shifted out; the
    // launch strobe is gated by ready so it can never fire while TX is busy.
    always_comb begin
        o_tx_data  = '0;
        o_tx_start = 1'b0;
        o_busy     = 1'b0;
        o_done     = 1'b0;
        o_mux_sel  = muxSelReg;

        case (stateReg)
            HDR: begin
                o_tx_data  = HEADER;
                o_tx_start = i_tx_ready;
            end
            HWAIT: begin
                o_tx_data = HEADER;
            end
            SEND: begin
                o_tx_data  = capBytes[byteReg];
                o_tx_start = i_tx_ready;
            end
            BWAIT: begin
                o_tx_data = capBytes[byteReg];
            end
            FIN: begin
                o_done = 1'b1;
            end
            default: begin
                o_tx_data = '0;
            end
        endcase

        o_busy = (stateReg != IDLE) && (stateReg != FIN);
    end

endmodule

// File: tb/tb_debug_latch_dumper.sv
// Directed bench for debug_latch_dumper: a registered mux model, a UART TX
// model that finishes each byte 10 clocks after launch, and a linear
// sequence of dumps covering stalls, spurious strobes, reset and restarts.
module tb_debug_latch_dumper;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_start;
    logic [31:0] i_mux_data;
    logic        i_tx_ready;
    logic        i_tx_done;
    logic [6:0]  o_mux_sel;
    logic [7:0]  o_tx_data;
    logic        o_tx_start;
    logic        o_busy;
    logic        o_done;

    logic        holdReady;
    logic        spurDone;
    logic        txBusy    = 1'b0;
    logic        modelDone = 1'b0;
    int          txCnt     = 0;
    logic [31:0] muxData   = '0;
    logic [7:0]  captured [$];
    int          doneCount = 0;
    int          badStart  = 0;
    int          checks    = 0;
    int          failures  = 0;
    logic [7:0]  expBytes [81];
    logic [6:0]  tbl [20];

    always #5 clk = ~clk;

    debug_latch_dumper dut (
        .clk        (clk),
        .rst        (rst),
        .i_start    (i_start),
        .i_mux_data (i_mux_data),
        .i_tx_ready (i_tx_ready),
        .i_tx_done  (i_tx_done),
        .o_mux_sel  (o_mux_sel),
        .o_tx_data  (o_tx_data),
        .o_tx_start (o_tx_start),
        .o_busy     (o_busy),
        .o_done     (o_done)
    );

    assign i_mux_data = muxData;
    assign i_tx_ready = !txBusy && !holdReady;
    assign i_tx_done  = modelDone | spurDone;

    // Latch-select mux: registered word tagged with the selector it saw.
    always @(posedge clk) begin
        muxData <= {1'b0, o_mux_sel, 24'h00BEEF};
    end

    // UART TX model: records each launched byte, done pulse 10 clocks later.
    always @(posedge clk) begin
        modelDone <= 1'b0;
        if (o_tx_start && i_tx_ready) begin
            captured.push_back(o_tx_data);
            txBusy <= 1'b1;
            txCnt  <= 10;
        end else if (txBusy) begin
            if (txCnt == 1) begin
                modelDone <= 1'b1;
                txBusy    <= 1'b0;
            end
            txCnt <= txCnt - 1;
        end
    end

    // Event counters for done pulses and illegal launches.
    always @(posedge clk) begin
        if (o_done) doneCount <= doneCount + 1;
        if (o_tx_start && !i_tx_ready) badStart <= badStart + 1;
    end

    task automatic check(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] getByte(input int i);
        if (i < captured.size()) return {24'h0, captured[i]};
        return 32'hFFFF_FFFF;
    endfunction

    task automatic compareDump(input string tag);
        check(32'(captured.size()), 81, {tag, "_byte_count"});
        for (int i = 0; i < 81; i++) begin
            check(getByte(i), {24'h0, expBytes[i]}, $sformatf("%s_byte%0d", tag, i));
        end
    endtask

    // Called at a negedge: one-cycle start pulse, busy expected next cycle.
    task automatic pulseStart(input string tag);
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        check(32'(o_busy), 1, {tag, "_busy_after_start"});
    endtask

    task automatic waitDone(input string tag);
        int n;
        n = 0;
        while (o_done !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check(32'(o_done), 1, {tag, "_done_seen"});
    endtask

    task automatic waitBytes(input int cnt, input string tag);
        int n;
        n = 0;
        while (captured.size() < cnt && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check(32'(captured.size() >= cnt), 1, {tag, "_bytes_reached"});
    endtask

    initial begin
        int         n;
        int         doneBase;
        int         startsSeen;
        int         dataChg;
        int         selChg;
        logic [7:0] snapData;
        logic [6:0] snapSel;

        rst       = 1'b1;
        i_start   = 1'b0;
        holdReady = 1'b0;
        spurDone  = 1'b0;

        tbl = '{7'h00, 7'h01, 7'h10, 7'h11, 7'h13, 7'h14, 7'h15, 7'h16, 7'h20, 7'h21,
                7'h23, 7'h24, 7'h25, 7'h30, 7'h31, 7'h32, 7'h33, 7'h34, 7'h40, 7'h41};
        expBytes[0] = 8'hA5;
        for (int k = 0; k < 20; k++) begin
            expBytes[4*k+1] = {1'b0, tbl[k]};
            expBytes[4*k+2] = 8'h00;
            expBytes[4*k+3] = 8'hBE;
            expBytes[4*k+4] = 8'hEF;
        end

        // Reset state
        repeat (3) @(negedge clk);
        check(32'(o_mux_sel),  0, "reset_mux_sel");
        check(32'(o_tx_data),  0, "reset_tx_data");
        check(32'(o_tx_start), 0, "reset_tx_start");
        check(32'(o_busy),     0, "reset_busy");
        check(32'(o_done),     0, "reset_done");
        rst = 1'b0;
        @(negedge clk);

        // Dump 1: full sequence, fresh mux data per entry
        doneBase = doneCount;
        pulseStart("d1");
        waitDone("d1");
        compareDump("d1");
        check(getByte(17), 32'h13, "d1_entry13_b0");
        check(getByte(18), 32'h00, "d1_entry13_b1");
        check(getByte(19), 32'hBE, "d1_entry13_b2");
        check(getByte(20), 32'hEF, "d1_entry13_b3");
        i_start = 1'b1;             // coincides with done: must be ignored
        @(negedge clk);
        i_start = 1'b0;
        check(32'(o_busy),      0, "d1_busy_after_done");
        check(32'(o_mux_sel),   0, "d1_sel_after_done");
        check(doneCount - doneBase, 1, "d1_done_once");
        repeat (3) @(negedge clk);
        check(32'(o_busy), 0, "d1_start_with_done_ignored");

        // Dump 2: ready stall mid-word, start while busy, spurious done in SEL
        captured.delete();
        doneBase = doneCount;
        pulseStart("d2");
        waitBytes(11, "d2_stall");
        holdReady = 1'b1;
        repeat (15) @(negedge clk);
        snapData = o_tx_data;
        snapSel  = o_mux_sel;
        check(32'(snapData), 32'hBE, "d2_stall_tx_data");
        check(32'(snapSel),  32'h10, "d2_stall_mux_sel");
        startsSeen = 0;
        dataChg    = 0;
        selChg     = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (o_tx_start) startsSeen++;
            if (o_tx_data !== snapData) dataChg++;
            if (o_mux_sel !== snapSel) selChg++;
        end
        check(startsSeen, 0, "d2_stall_no_start");
        check(dataChg,    0, "d2_stall_data_stable");
        check(selChg,     0, "d2_stall_sel_stable");
        check(32'(captured.size()), 11, "d2_stall_no_byte");
        holdReady = 1'b0;
        waitBytes(30, "d2_restart");
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        check(32'(o_busy), 1, "d2_busy_after_restart_req");
        waitBytes(33, "d2_word_end");
        n = 0;
        while (i_tx_done !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check(32'(i_tx_done), 1, "d2_word_end_done");
        @(negedge clk);             // DUT now in SEL
        spurDone = 1'b1;
        @(negedge clk);
        spurDone = 1'b0;
        waitDone("d2");
        compareDump("d2");
        @(negedge clk);
        check(doneCount - doneBase, 1, "d2_done_once");
        repeat (5) @(negedge clk);
        check(32'(o_busy), 0, "d2_no_queued_restart");
        check(32'(captured.size()), 81, "d2_no_extra_bytes");

        // Dump 3: reset mid-dump, outputs cleared without a clock edge
        captured.delete();
        pulseStart("d3");
        waitBytes(45, "d3");
        rst = 1'b1;
        #1;
        check(32'(o_mux_sel),  0, "rst_mid_mux_sel");
        check(32'(o_tx_data),  0, "rst_mid_tx_data");
        check(32'(o_tx_start), 0, "rst_mid_tx_start");
        check(32'(o_busy),     0, "rst_mid_busy");
        check(32'(o_done),     0, "rst_mid_done");
        repeat (20) @(negedge clk);
        rst = 1'b0;
        captured.delete();
        @(negedge clk);

        // Dump 4: restart after reset begins again from the header
        doneBase = doneCount;
        pulseStart("d4");
        waitDone("d4");
        check(getByte(0), 32'hA5, "d4_first_header");
        check(getByte(1), 32'h00, "d4_first_entry");
        compareDump("d4");
        captured.delete();

        // Dump 5: back-to-back, start one clock after done
        @(negedge clk);
        check(doneCount - doneBase, 1, "d4_done_once");
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        check(32'(o_busy), 1, "d5_busy_back_to_back");
        doneBase = doneCount;
        waitDone("d5");
        compareDump("d5");
        @(negedge clk);
        check(doneCount - doneBase, 1, "d5_done_once");
        check(32'(o_busy), 0, "d5_idle_after");

        check(badStart, 0, "tx_start_without_ready");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
